// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - multiplier sequencing controller with one-entry result cache and completion watchdog
module mul_ctrl #(
  parameter int MAX_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_sign0,
  input  logic        req_sign1,
  input  logic        req_hi,
  input  logic [31:0] req_m,
  input  logic [31:0] req_r,
  input  logic        flush,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        err,
  output logic        core_go,
  output logic        core_sign0,
  output logic        core_sign1,
  output logic [31:0] core_m,
  output logic [31:0] core_r,
  input  logic        core_done,
  input  logic [63:0] core_result
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  logic          lat_sign0;
  logic          lat_sign1;
  logic [31:0]   lat_m;
  logic [31:0]   lat_r;

  logic          c_valid;
  logic          c_sign0;
  logic          c_sign1;
  logic [31:0]   c_m;
  logic [31:0]   c_r;
  logic [63:0]   c_prod;

  logic          err_q;

  logic          hit;
  logic          start;
  logic          timeout;
  logic          cache_wr;

  // The cache tag includes both signedness bits so MUL/MULHU pairs never alias.
  assign hit = c_valid & (req_m == c_m) & (req_r == c_r)
             & (req_sign0 == c_sign0) & (req_sign1 == c_sign1);

  assign start    = (state == IDLE) & req_valid & ~flush & ~hit;
  // Watchdog counts every cycle the core owes us a completion, including DRAIN.
  assign timeout  = ((state == RUN) | (state == DRAIN)) & ~core_done & (cnt == CNT_LAST);
  // A flushed op never reaches the cache, even when core_done lands in the flush cycle.
  assign cache_wr = (state == RUN) & core_done & ~flush;

  assign core_sign0 = lat_sign0;
  assign core_sign1 = lat_sign1;
  assign core_m     = lat_m;
  assign core_r     = lat_r;
  assign err        = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; a flush only diverts to DRAIN because the core cannot be aborted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (core_done || timeout) begin
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (core_done || timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: start pulse on the first RUN cycle, zero-latency answer on a cache hit.
  always_comb begin
    busy    = (state != IDLE);
    core_go = (state == RUN) && (cnt == '0);
    done    = req_valid & ~flush & hit & (state == IDLE);
    result  = req_hi ? c_prod[63:32] : c_prod[31:0];
  end

  // Operand latch, cycle counter, result cache and sticky watchdog error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      lat_sign0 <= 1'b0;
      lat_sign1 <= 1'b0;
      lat_m     <= '0;
      lat_r     <= '0;
      c_valid   <= 1'b0;
      c_sign0   <= 1'b0;
      c_sign1   <= 1'b0;
      c_m       <= '0;
      c_r       <= '0;
      c_prod    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (start) begin
        lat_sign0 <= req_sign0;
        lat_sign1 <= req_sign1;
        lat_m     <= req_m;
        lat_r     <= req_r;
        cnt       <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
      if (cache_wr) begin
        c_valid <= 1'b1;
        c_sign0 <= lat_sign0;
        c_sign1 <= lat_sign1;
        c_m     <= lat_m;
        c_r     <= lat_r;
        c_prod  <= core_result;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl with a latency-programmable core stub
module tb_mul_ctrl;

  localparam int MAXC   = 8;
  localparam int BUDGET = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_sign0, req_sign1, req_hi;
  logic [31:0] req_m, req_r;
  logic        flush;
  logic        done, busy, err, core_go, core_sign0, core_sign1;
  logic [31:0] result, core_m, core_r;
  logic        core_done;
  logic [63:0] core_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_ctrl #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_sign0(req_sign0), .req_sign1(req_sign1), .req_hi(req_hi),
    .req_m(req_m), .req_r(req_r), .flush(flush),
    .done(done), .result(result), .busy(busy), .err(err),
    .core_go(core_go), .core_sign0(core_sign0), .core_sign1(core_sign1),
    .core_m(core_m), .core_r(core_r),
    .core_done(core_done), .core_result(core_result)
  );

  // Core stub: latches operands on core_go and pulses done stub_lat cycles later.
  int          stub_lat   = 4;
  bit          stub_never = 1'b0;
  logic        stub_act   = 1'b0;
  int          stub_ctr   = 0;
  logic [63:0] stub_prod  = '0;
  logic        stub_done;

  function automatic logic [63:0] ext(input logic [31:0] v, input logic s);
    return s ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

  always @(posedge clk) begin
    if (core_go) begin
      stub_act  <= 1'b1;
      stub_ctr  <= stub_lat - 1;
      stub_prod <= ext(core_m, core_sign0) * ext(core_r, core_sign1);
    end else if (stub_act) begin
      if (stub_ctr == 0) stub_act <= 1'b0;
      else stub_ctr <= stub_ctr - 1;
    end
  end

  assign stub_done   = stub_act && (stub_ctr == 0) && !stub_never;
  assign core_done   = stub_done;
  assign core_result = stub_done ? stub_prod : 64'hDEAD_BEEF_DEAD_BEEF;

  // Reference product from signed/unsigned integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] r,
                                           input logic s0, input logic s1);
    longint a, b;
    a = s0 ? longint'($signed(m)) : longint'(m);
    b = s1 ? longint'($signed(r)) : longint'(r);
    return 64'(a * b);
  endfunction

  function automatic logic [31:0] sel(input logic [63:0] p, input logic hi);
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until done (cycle 0 = first cycle the request is presented).
  task automatic run_op(input logic s0, input logic s1, input logic hi,
                        input logic [31:0] m, input logic [31:0] r,
                        output int lat, output logic [31:0] res, output int gos,
                        output int busy_n, output int go_at,
                        output logic [31:0] go_m, output logic [31:0] go_r);
    lat = -1; res = '0; gos = 0; busy_n = 0; go_at = -1; go_m = '0; go_r = '0;
    req_valid = 1'b1; req_sign0 = s0; req_sign1 = s1; req_hi = hi; req_m = m; req_r = r;
    for (int c = 0; c <= BUDGET; c++) begin
      @(negedge clk);
      if (core_go) begin
        gos++;
        if (go_at < 0) begin
          go_at = c; go_m = core_m; go_r = core_r;
        end
      end
      if (busy) busy_n++;
      if (done) begin
        lat = c; res = result;
      end
      next_cycle();
      if (lat >= 0) break;
    end
  endtask

  task automatic do_op(input string name, input logic s0, input logic s1, input logic hi,
                       input logic [31:0] m, input logic [31:0] r,
                       input logic [31:0] exp_res, input bit miss, input int lat_cfg);
    int lat, gos, busy_n, go_at;
    logic [31:0] res, gm, gr;
    stub_lat = lat_cfg;
    run_op(s0, s1, hi, m, r, lat, res, gos, busy_n, go_at, gm, gr);
    check({name, "_latency"}, 64'(lat), miss ? 64'(lat_cfg + 2) : 64'd0);
    check({name, "_result"}, {32'b0, res}, {32'b0, exp_res});
    check({name, "_go_count"}, 64'(gos), miss ? 64'd1 : 64'd0);
    check({name, "_busy_cycles"}, 64'(busy_n), miss ? 64'(lat_cfg + 1) : 64'd0);
    if (miss) begin
      check({name, "_go_cycle"}, 64'(go_at), 64'd1);
      check({name, "_core_m"}, {32'b0, gm}, {32'b0, m});
      check({name, "_core_r"}, {32'b0, gr}, {32'b0, r});
    end
  endtask

  typedef struct {
    logic        s0;
    logic        s1;
    logic        hi;
    logic [31:0] m;
    logic [31:0] r;
    logic [31:0] exp_res;
    bit          miss;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic        mc_valid, mc_s0, mc_s1;
    logic [31:0] mc_m, mc_r;
    logic [63:0] mc_prod;
    logic [31:0] pool[4];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd7,         32'd6,         32'd42,        1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd2,         32'h0000_0000, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'h0000_0001, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd2,         32'h0000_0000, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_sign0 = 1'b0; req_sign1 = 1'b0; req_hi = 1'b0;
    req_m = '0; req_r = '0; flush = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_core_go", {63'b0, core_go}, 64'd0);
    check("reset_err", {63'b0, err}, 64'd0);
    check("reset_core_m", {32'b0, core_m}, 64'd0);
    check("reset_core_r", {32'b0, core_r}, 64'd0);
    next_cycle();
    reset_n = 1'b1;

    // Directed vectors, stub latency 4.
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("tbl%0d", i), tbl[i].s0, tbl[i].s1, tbl[i].hi, tbl[i].m, tbl[i].r,
            tbl[i].exp_res, tbl[i].miss, 4);
    end
    req_valid = 1'b0;
    next_cycle();

    // Flush in the second RUN cycle: DRAIN, result discarded, cache keeps the old entry.
    stub_lat = 4;
    req_valid = 1'b1; req_sign0 = 1'b1; req_sign1 = 1'b1; req_hi = 1'b0; req_m = 32'd5; req_r = 32'd9;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      flush = (c == 2) || (c == 4);
      if (c == 3) req_valid = 1'b0;
      @(negedge clk);
      if (c == 2) check("flush_run_done", {63'b0, done}, 64'd0);
      if (c == 5) check("drain_busy", {63'b0, busy}, 64'd1);
      if (c == 6) check("drain_exit_busy", {63'b0, busy}, 64'd0);
    end
    next_cycle();
    flush = 1'b0;
    do_op("flush_prior_hit", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 4);
    do_op("flush_rerun", 1'b1, 1'b1, 1'b0, 32'd5, 32'd9, 32'd45, 1'b1, 4);

    // Request with flush in IDLE: no start, no done (miss and hit cases).
    req_valid = 1'b1; req_sign0 = 1'b0; req_sign1 = 1'b0; req_hi = 1'b0; req_m = 32'd3; req_r = 32'd3;
    flush = 1'b1;
    @(negedge clk);
    check("idle_flush_miss_done", {63'b0, done}, 64'd0);
    next_cycle();
    req_sign0 = 1'b1; req_sign1 = 1'b1; req_m = 32'd5; req_r = 32'd9;
    @(negedge clk);
    check("idle_flush_no_start", {62'b0, busy, core_go}, 64'd0);
    check("idle_flush_hit_done", {63'b0, done}, 64'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("idle_hit_after_flush", {31'b0, done, result}, {31'b0, 1'b1, 32'd45});
    next_cycle();

    // Flush coincident with core_done: no cache write, IDLE next cycle.
    stub_lat = 4;
    req_sign0 = 1'b0; req_sign1 = 1'b0; req_m = 32'd3; req_r = 32'd3;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      flush = (c == 5);
      if (c == 6) req_valid = 1'b0;
      @(negedge clk);
      if (c == 5) check("coinc_core_done", {63'b0, core_done}, 64'd1);
      if (c == 6) check("coinc_idle", {63'b0, busy}, 64'd0);
    end
    next_cycle();
    flush = 1'b0;
    do_op("coinc_old_hit", 1'b1, 1'b1, 1'b1, 32'd5, 32'd9, 32'd0, 1'b0, 4);
    do_op("coinc_rerun", 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd9, 1'b1, 4);

    // Watchdog: core never completes.
    stub_never = 1'b1; stub_lat = 4;
    req_valid = 1'b1; req_sign0 = 1'b0; req_sign1 = 1'b0; req_hi = 1'b0; req_m = 32'd11; req_r = 32'd13;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (c == 9) req_valid = 1'b0;
      @(negedge clk);
      if (c == 8) check("wdog_pre_state", {62'b0, busy, err}, 64'd2);
      if (c == 9) check("wdog_fire_state", {62'b0, busy, err}, 64'd1);
    end
    next_cycle();
    stub_never = 1'b0;
    do_op("wdog_old_hit", 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, 4);
    check("wdog_err_sticky1", {63'b0, err}, 64'd1);
    do_op("wdog_rerun", 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd143, 1'b1, 2);
    check("wdog_err_sticky2", {63'b0, err}, 64'd1);

    // Reset mid-RUN, then a stray core_done in IDLE.
    stub_lat = 4;
    req_valid = 1'b1; req_sign0 = 1'b1; req_sign1 = 1'b1; req_hi = 1'b0; req_m = 32'd100; req_r = 32'd200;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      reset_n = (c != 2);
      if (c == 2) req_valid = 1'b0;
      @(negedge clk);
      if (c == 3) check("rst_mid_state", {61'b0, busy, err, core_go}, 64'd0);
      if (c == 5) check("rst_stray_done_idle", {62'b0, core_done, busy}, 64'd2);
      if (c == 6) check("rst_after_stray_busy", {63'b0, busy}, 64'd0);
    end
    next_cycle();
    do_op("rst_cache_cleared", 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd143, 1'b1, 3);
    do_op("rst_fresh_hit", 1'b0, 1'b0, 1'b1, 32'd11, 32'd13, 32'd0, 1'b0, 3);

    // Randomized ops against the cache-level reference model.
    mc_valid = 1'b1; mc_s0 = 1'b0; mc_s1 = 1'b0; mc_m = 32'd11; mc_r = 32'd13;
    mc_prod = ref_prod(32'd11, 32'd13, 1'b0, 1'b0);
    pool[0] = 32'h8000_0000; pool[1] = 32'h0000_0002; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h1234_5678;
    for (int i = 0; i < 40; i++) begin
      logic s0, s1, hi, is_hit;
      logic [31:0] m, r, exp;
      int lc;
      if (($urandom_range(0, 1) == 1) && mc_valid) begin
        s0 = mc_s0; s1 = mc_s1; m = mc_m; r = mc_r;
      end else begin
        s0 = 1'($urandom_range(0, 1)); s1 = 1'($urandom_range(0, 1));
        m = pool[$urandom_range(0, 3)]; r = pool[$urandom_range(0, 3)];
      end
      hi = 1'($urandom_range(0, 1));
      lc = $urandom_range(1, 6);
      is_hit = mc_valid && (m == mc_m) && (r == mc_r) && (s0 == mc_s0) && (s1 == mc_s1);
      exp = is_hit ? sel(mc_prod, hi) : sel(ref_prod(m, r, s0, s1), hi);
      do_op($sformatf("rnd%0d", i), s0, s1, hi, m, r, exp, !is_hit, lc);
      if (!is_hit) begin
        mc_valid = 1'b1; mc_s0 = s0; mc_s1 = s1; mc_m = m; mc_r = r; mc_prod = ref_prod(m, r, s0, s1);
      end
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 2)) next_cycle();
      end
    end
    req_valid = 1'b0;
    next_cycle();

    // err clears only on reset.
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("final_reset_err", {63'b0, err}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Sequencing controller between the execute stage and the iterative multiplier core. It latches operands, issues a single-cycle start to the core and waits for completion. Completed results go into a one-entry result cache, so a MUL/MULH pair on identical operands and signedness runs the core once. It also handles pipeline flushes while the non-abortable core is busy and runs a watchdog on core completion.

## Interface
- MAX_CYCLES, default 64: watchdog limit, in cycles spent in RUN/DRAIN without core_done.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  execute stage has a multiply op; held with stable req_* until done is seen.
- req_sign0  in  1  multiplicand (m) treated as signed.
- req_sign1  in  1  multiplier (r) treated as signed.
- req_hi  in  1  return the upper product half (MULH/MULHSU/MULHU); 0 returns the lower half (MUL).
- req_m  in  32  multiplicand.
- req_r  in  32  multiplier.
- flush  in  1  kill the in-flight op (write-back exception).
- done  out  1  result valid this cycle; combinational.
- result  out  32  selected product half; valid only when done=1.
- busy  out  1  state != IDLE.
- err  out  1  sticky watchdog error.
- core_go  out  1  single-cycle start pulse to the core.
- core_sign0, core_sign1  out  1  latched signedness.
- core_m, core_r  out  32  latched operands, stable throughout RUN/DRAIN.
- core_done  in  1  core completion pulse.
- core_result  in  64  product; valid in the core_done cycle.

## Operation
- State registers: state (IDLE/RUN/DRAIN), cycle counter cnt, operand/sign latch, and cache entry (valid, m, r, sign0, sign1, 64-bit product).
- Cache hit: cache_valid & req_m==c_m & req_r==c_r & req_sign0==c_sign0 & req_sign1==c_sign1.
- done = req_valid & ~flush & hit & state==IDLE.
- result = req_hi ? c_prod[63:32] : c_prod[31:0].
- IDLE:
  - req_valid & ~flush & ~hit: latch operands and signs, clear cnt, go to RUN.
  - All other cases: remain in IDLE.
- RUN:
  - core_go=1 in the first RUN cycle only.
  - cnt increments each cycle.
  - core_done & ~flush: write the cache (valid=1, tags from the latch, product=core_result), go to IDLE.
  - flush & ~core_done: go to DRAIN.
  - flush & core_done in the same cycle: discard the result, no cache write, go to IDLE.
- DRAIN:
  - Wait for core_done, discard the result, go to IDLE. The core cannot be aborted.
  - flush in DRAIN has no additional effect.
- req_valid dropping during RUN does not abort the op; the result is still cached.
- Watchdog: if cnt reaches MAX_CYCLES-1 in RUN/DRAIN without core_done, set err=1, go to IDLE, no cache write. err clears only on reset.
- A cache write replaces the previous entry. The cache is never invalidated except by reset.
- The cache matches signedness exactly. MUL followed by MULHU on the same operands is a miss.

## Timing
- Reset values: state=IDLE, cache_valid=0, err=0, cnt=0, operand/sign latch=0. With those values: done=0, busy=0, core_go=0, core_m=core_r=0.
- Miss latency: request first seen in cycle T.
  - RUN and core_go=1 in cycle T+1.
  - Core with latency L asserts core_done at T+1+L.
  - Cache written at that edge; state is IDLE at T+2+L.
  - done=1 at T+2+L if the request is still held.
- Hit latency: 0 cycles (done in the same cycle as req_valid).
- Back-to-back: a hit in the cycle the FSM returns to IDLE is valid. A new miss starts RUN the following cycle.
- Reset asserted mid-RUN/DRAIN: immediate return to IDLE. A later core_done in IDLE is ignored, and the cache is not written.
- core_done arriving in IDLE is ignored.

## Test plan
- Reset, then req m=7, r=6, sign0=sign1=1, hi=0, with stub core L=4 → core_go at cycle 1, core_m=7, core_r=6; done at cycle 6, result=42; busy=1 in cycles 1–5.
- Follow-on MULH (same m, r, signs, hi=1) after a MUL with m=0x80000000, r=2 → done in the request cycle with no core_go, result=0xFFFFFFFF. A following MULHU (sign0=sign1=0) misses, runs the core, and returns 0x00000001.
- flush in cycle 2 of a RUN → DRAIN; core_done discarded, cache unchanged. A re-request of the prior cached operands hits; the flushed operands miss and rerun.
- flush coincident with core_done → no cache write, IDLE next cycle. req_valid together with flush while in IDLE → no start, done=0.
- Core stub never asserts done, MAX_CYCLES=8 → err=1 after 8 cycles in RUN, state IDLE; err stays high across later requests until reset_n=0.
- reset_n low mid-RUN, then a stray core_done after reset → state IDLE, cache_valid=0, no done for any request until a fresh run completes.
